// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO drain arbiter.
//   arb_state_t  - arbiter FSM state encoding (IDLE, GRANT, GAP)
//   BURST_CNT_W  - width of the per-grant burst counter (MAX_BURST up to 15)
//   port_lsb()   - bit offset of a port's word inside a packed per-port bus
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int unsigned BURST_CNT_W = 4;

    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker (purely combinational).
//   req        - per-port request vector
//   last_grant - port granted most recently; the search starts one above it
//   found      - at least one port is requesting
//   index      - first requesting port found, wrapping modulo 2**LOG_N
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int LOG_N = 2
) (
    input  logic [(1<<LOG_N)-1:0] req,
    input  logic [LOG_N-1:0]      last_grant,
    output logic                  found,
    output logic [LOG_N-1:0]      index
);

    localparam int unsigned N = 1 << LOG_N;

    // Offsets 1..N from last_grant; the truncating add gives the wrap, and
    // offset N lands back on last_grant itself as the lowest priority.
    always_comb begin
        logic [LOG_N-1:0] cand;
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = last_grant + LOG_N'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of up to N_PORTS slow-read FIFOs into one registered
// valid/ready output stream. One port is granted at a time for a burst of at
// most MAX_BURST words; each read is followed by a one-cycle gap because the
// FIFO's has_data is not valid in the cycle after a read.
//   clock, reset_n  - posedge clock, asynchronous active-low reset
//   enable          - global clock enable; low freezes all state, no reads
//   fifo_has_data   - per-port non-empty flags
//   fifo_dout       - per-port head words, port i at [i*WIDTH +: WIDTH]
//   fifo_read       - one-hot dequeue strobe (combinational)
//   out_data/out_src/out_valid - registered output word, its source port, valid
//   out_ready       - consumer accepts the output word this cycle
//   busy            - arbiter is not idle
module fifo_drain_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 36,
    parameter int LOG_N     = 2,
    parameter int MAX_BURST = 4,
    localparam int N_PORTS  = 1 << LOG_N
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [N_PORTS-1:0]       fifo_has_data,
    input  logic [N_PORTS*WIDTH-1:0] fifo_dout,
    output logic [N_PORTS-1:0]       fifo_read,
    output logic [WIDTH-1:0]         out_data,
    output logic [LOG_N-1:0]         out_src,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST);
    localparam logic [BURST_CNT_W-1:0] BURST_ONE  = BURST_CNT_W'(1);

    arb_state_t             state;
    logic [LOG_N-1:0]       last_grant;
    logic [BURST_CNT_W-1:0] burst_cnt;

    logic                   pick_found;
    logic [LOG_N-1:0]       pick_idx;
    logic                   slot_free;
    logic                   rd_en;
    logic [LOG_N-1:0]       rd_idx;
    logic [WIDTH-1:0]       rd_word;

    rr_priority_pick #(
        .LOG_N (LOG_N)
    ) u_pick (
        .req        (fifo_has_data),
        .last_grant (last_grant),
        .found      (pick_found),
        .index      (pick_idx)
    );

    always_comb begin
        slot_free = ~out_valid | out_ready;
        rd_en     = 1'b0;
        rd_idx    = last_grant;
        unique case (state)
            IDLE: begin
                rd_en  = enable & slot_free & pick_found;
                rd_idx = pick_idx;
            end
            GRANT: begin
                rd_en = enable & slot_free & fifo_has_data[last_grant];
            end
            default: begin
            end
        endcase
        rd_word = fifo_dout[port_lsb(int'(rd_idx), WIDTH) +: WIDTH];
    end

    // Reset gates only the strobe itself so reset_n never reaches flop data.
    assign fifo_read = (rd_en && reset_n) ? (N_PORTS'(1) << rd_idx) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= LOG_N'(N_PORTS - 1);
            burst_cnt  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
        end else if (enable) begin
            if (rd_en) begin
                out_data  <= rd_word;
                out_src   <= rd_idx;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (pick_found && slot_free) begin
                        last_grant <= pick_idx;
                        burst_cnt  <= BURST_ONE;
                        state      <= (MAX_BURST == 1) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    state <= (burst_cnt == BURST_LAST) ? IDLE : GRANT;
                end
                GRANT: begin
                    if (!fifo_has_data[last_grant]) begin
                        state <= IDLE;
                    end else if (slot_free) begin
                        burst_cnt <= burst_cnt + BURST_ONE;
                        state     <= GAP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter: a burst-4 instance fed by small FIFO
// models with the one-cycle read gap, plus a burst-1 instance for wrap-around.
module tb_fifo_drain_arbiter;
    import fifo_arb_pkg::*;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b1;
    logic         out_ready = 1'b1;
    logic [3:0]   fifo_has_data;
    logic [143:0] fifo_dout;
    logic [3:0]   fifo_read;
    logic [35:0]  out_data;
    logic [1:0]   out_src;
    logic         out_valid;
    logic         busy;

    logic         en1 = 1'b0;
    logic [3:0]   prev_read1 = '0;
    logic [3:0]   has_data1;
    logic [143:0] dout1;
    logic [3:0]   fifo_read1;
    logic [35:0]  out_data1;
    logic [1:0]   out_src1;
    logic         out_valid1;
    logic         busy1;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO models
    logic [35:0] mem [4][64];
    logic [5:0]  rd_ptr [4] = '{default: 6'd0};
    logic [5:0]  wr_ptr [4] = '{default: 6'd0};
    logic [3:0]  gap = '0;

    logic        collect = 1'b0;
    logic [37:0] log_q [$];
    int          multi_hot_err = 0;
    int          bad_read_err  = 0;

    always #5 clock = ~clock;

    fifo_drain_arbiter #(.WIDTH(36), .LOG_N(2), .MAX_BURST(4)) u_dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .fifo_has_data(fifo_has_data), .fifo_dout(fifo_dout),
        .fifo_read(fifo_read), .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    fifo_drain_arbiter #(.WIDTH(36), .LOG_N(2), .MAX_BURST(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .enable(en1),
        .fifo_has_data(has_data1), .fifo_dout(dout1),
        .fifo_read(fifo_read1), .out_data(out_data1), .out_src(out_src1),
        .out_valid(out_valid1), .out_ready(1'b1), .busy(busy1)
    );

    always_comb begin
        fifo_has_data = '0;
        fifo_dout     = '0;
        for (int i = 0; i < 4; i++) begin
            fifo_has_data[i]   = (rd_ptr[i] != wr_ptr[i]) && !gap[i];
            fifo_dout[i*36 +: 36] = mem[i][rd_ptr[i]];
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (fifo_read[i]) begin
                rd_ptr[i] <= rd_ptr[i] + 6'd1;
                gap[i]    <= 1'b1;
            end else begin
                gap[i] <= 1'b0;
            end
        end
        prev_read1 <= fifo_read1;
    end

    assign has_data1 = ~prev_read1;
    assign dout1     = {36'h103, 36'h102, 36'h101, 36'h100};

    always @(posedge clock) begin
        #1;
        if (collect && out_valid && out_ready) log_q.push_back({out_src, out_data});
        if ($countones(fifo_read) > 1) multi_hot_err++;
        if ((fifo_read & ~fifo_has_data) != 4'b0) bad_read_err++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int port, input logic [35:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            mem[port][wr_ptr[port]] = base + 36'(k);
            wr_ptr[port] = wr_ptr[port] + 6'd1;
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < 4; i++)
            if (rd_ptr[i] != wr_ptr[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            tick();
            if (!busy && all_empty()) done = 1'b1;
        end
        check_eq(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_valid(input string tag, input logic [35:0] exp);
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check_eq({tag, "_seen"}, 64'(seen), 64'd1);
        check_eq(tag, 64'(out_data), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int          exp_src [12] = '{0,0,0,0,1,1,1,1,0,0,1,1};
        int          exp_n   [12] = '{0,1,2,3,0,1,2,3,4,5,4,5};
        logic [3:0]  exp_rd1 [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [37:0] e;
        bit          got12;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        tick();
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_data", 64'(out_data), 64'd0);
        check_eq("rst_src", 64'(out_src), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_read", 64'(fifo_read), 64'd0);
        check_eq("rst_last_grant", 64'(u_dut.last_grant), 64'd3);
        check_eq("rst_burst", 64'(u_dut.burst_cnt), 64'd0);

        // Single port: port 2 holds A,B,C
        load(2, 36'hA00, 3);
        #1;
        check_eq("sp_rd0", 64'(fifo_read), 64'b0100);
        tick();
        check_eq("sp_outA", 64'(out_data), 64'hA00);
        check_eq("sp_vA", 64'(out_valid), 64'd1);
        check_eq("sp_srcA", 64'(out_src), 64'd2);
        check_eq("sp_gap0", 64'(fifo_read), 64'd0);
        check_eq("sp_busy", 64'(busy), 64'd1);
        tick();
        check_eq("sp_rd1", 64'(fifo_read), 64'b0100);
        check_eq("sp_vdrop", 64'(out_valid), 64'd0);
        tick();
        check_eq("sp_outB", 64'(out_data), 64'hA01);
        check_eq("sp_vB", 64'(out_valid), 64'd1);
        check_eq("sp_gap1", 64'(fifo_read), 64'd0);
        tick();
        check_eq("sp_rd2", 64'(fifo_read), 64'b0100);
        tick();
        check_eq("sp_outC", 64'(out_data), 64'hA02);
        check_eq("sp_srcC", 64'(out_src), 64'd2);
        tick();
        check_eq("sp_grant_state", 64'(u_dut.state), 64'(GRANT));
        check_eq("sp_empty_rd", 64'(fifo_read), 64'd0);
        tick();
        check_eq("sp_idle_busy", 64'(busy), 64'd0);
        check_eq("sp_idle_valid", 64'(out_valid), 64'd0);

        // Two-port round robin, 6 words each
        collect = 1'b1;
        load(0, 36'hB00, 6);
        load(1, 36'hC00, 6);
        got12 = 1'b0;
        for (int n = 0; n < 80 && !got12; n++) begin
            tick();
            if (log_q.size() == 12 && !busy) got12 = 1'b1;
        end
        collect = 1'b0;
        check_eq("rr_count", 64'(log_q.size()), 64'd12);
        for (int k = 0; k < 12 && k < log_q.size(); k++) begin
            e = log_q[k];
            check_eq($sformatf("rr_src%0d", k), 64'(e[37:36]), 64'(exp_src[k]));
            check_eq($sformatf("rr_data%0d", k), 64'(e[35:0]),
                     64'(((exp_src[k] == 0) ? 36'hB00 : 36'hC00) + 36'(exp_n[k])));
        end

        // Backpressure: port 3, ready low for 5 cycles after the first word
        load(3, 36'hD00, 3);
        #1;
        check_eq("bp_rd0", 64'(fifo_read), 64'b1000);
        tick();
        check_eq("bp_out0", 64'(out_data), 64'hD00);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq($sformatf("bp_hold_v%0d", c), 64'(out_valid), 64'd1);
            check_eq($sformatf("bp_hold_d%0d", c), 64'(out_data), 64'hD00);
            check_eq($sformatf("bp_hold_rd%0d", c), 64'(fifo_read), 64'd0);
            check_eq($sformatf("bp_hold_cnt%0d", c), 64'(u_dut.burst_cnt), 64'd1);
        end
        check_eq("bp_state", 64'(u_dut.state), 64'(GRANT));
        tick();
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_rd", 64'(fifo_read), 64'b1000);
        tick();
        check_eq("bp_out1", 64'(out_data), 64'hD01);
        check_eq("bp_src1", 64'(out_src), 64'd3);
        wait_idle("bp_drain");

        // Reset mid-burst in GRANT with out_valid held
        load(1, 36'hE00, 4);
        #1;
        check_eq("rm_rd0", 64'(fifo_read), 64'b0010);
        tick();
        out_ready = 1'b0;
        tick();
        check_eq("rm_state", 64'(u_dut.state), 64'(GRANT));
        check_eq("rm_valid_pre", 64'(out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rm_valid", 64'(out_valid), 64'd0);
        check_eq("rm_busy", 64'(busy), 64'd0);
        check_eq("rm_read", 64'(fifo_read), 64'd0);
        check_eq("rm_data", 64'(out_data), 64'd0);
        load(0, 36'hF00, 1);
        out_ready = 1'b1;
        @(negedge clock) reset_n = 1'b1;
        #1;
        check_eq("rm_prio0", 64'(fifo_read), 64'b0001);
        tick();
        check_eq("rm_outF", 64'(out_data), 64'hF00);
        check_eq("rm_srcF", 64'(out_src), 64'd0);
        wait_valid("rm_noreplay", 36'hE01);
        wait_idle("rm_drain");

        // Enable freeze during GAP
        load(2, 36'h900, 2);
        #1;
        check_eq("en_rd0", 64'(fifo_read), 64'b0100);
        tick();
        check_eq("en_out0", 64'(out_data), 64'h900);
        enable = 1'b0;
        #1;
        check_eq("en_rd_off", 64'(fifo_read), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq($sformatf("en_state%0d", c), 64'(u_dut.state), 64'(GAP));
            check_eq($sformatf("en_valid%0d", c), 64'(out_valid), 64'd1);
            check_eq($sformatf("en_data%0d", c), 64'(out_data), 64'h900);
            check_eq($sformatf("en_rd%0d", c), 64'(fifo_read), 64'd0);
        end
        enable = 1'b1;
        #1;
        check_eq("en_resume_rd", 64'(fifo_read), 64'd0);
        tick();
        check_eq("en_grant", 64'(u_dut.state), 64'(GRANT));
        check_eq("en_rd1", 64'(fifo_read), 64'b0100);
        check_eq("en_vdrop", 64'(out_valid), 64'd0);
        tick();
        check_eq("en_out1", 64'(out_data), 64'h901);
        wait_idle("en_drain");

        // Wrap-around with MAX_BURST=1, all ports requesting, last_grant=3
        check_eq("wr_last_grant", 64'(u_dut1.last_grant), 64'd3);
        en1 = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("wr_rd%0d", k), 64'(fifo_read1), 64'(exp_rd1[k]));
            check_eq($sformatf("wr_busy%0d", k), 64'(busy1), 64'd0);
            if (k > 0) begin
                check_eq($sformatf("wr_src%0d", k), 64'(out_src1), 64'(k - 1));
                check_eq($sformatf("wr_valid%0d", k), 64'(out_valid1), 64'd1);
            end
            if (k == 1) check_eq("wr_data", 64'(out_data1), 64'h100);
            tick();
        end
        en1 = 1'b0;

        check_eq("multi_hot", 64'(multi_hot_err), 64'd0);
        check_eq("read_no_data", 64'(bad_read_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
